// File: rtl/clock_pkg.sv
// Purpose: shared mode encoding and default limits for the clock controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package clock_pkg;

   // Mode encoding as seen on o_mode; value 3 is unused and recovered to RUN.
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } mode_t;

   localparam int SEC_MAX_DEF       = 59;
   localparam int MIN_MAX_DEF       = 59;
   localparam int TIMEOUT_TICKS_DEF = 30;

   function automatic logic is_set_mode(input logic [1:0] m);
      return (m == SET_HOUR) || (m == SET_MIN);
   endfunction

endpackage

// File: rtl/edge_det.sv
// Purpose: rising-edge detector for a debounced, clock-synchronous button level.
// Latency: o_rise is combinational from i_lvl against the previous-cycle level.
// Backpressure: none; the history register resets to 1 so a button held through reset
// must be released before it can produce an edge.
// Ports: i_clk, i_rst (sync, active-high), i_lvl (button level), o_rise (edge strobe).
module edge_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_lvl,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prev <= 1'b1;
      end else begin
         r_prev <= i_lvl;
      end
   end

   assign o_rise = i_lvl & ~r_prev;

endmodule

// File: rtl/clock_ctrl.sv
// Purpose: run/set-mode controller for a HH:MM:SS clock; issues inc/clear pulses to counters.
// Latency: every output is registered; a pulse appears the cycle after its causing event.
// Backpressure: none; a tick or button edge is acted on in the cycle it arrives.
// Ports: i_clk, i_rst (sync, active-high), i_tick_1hz, i_mode_btn, i_inc_btn,
//        i_sec_val[5:0], i_min_val[5:0] -> o_sec_inc, o_min_inc, o_hour_inc,
//        o_sec_clr, o_mode[1:0], o_blink.
// Option: define CLOCK_CTRL_BLINK_EN to make o_blink toggle per tick in set modes;
//         otherwise o_blink is tied low and no blink phase register exists.
module clock_ctrl #(
   parameter int SEC_MAX       = clock_pkg::SEC_MAX_DEF,
   parameter int MIN_MAX       = clock_pkg::MIN_MAX_DEF,
   parameter int TIMEOUT_TICKS = clock_pkg::TIMEOUT_TICKS_DEF
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tick_1hz,
   input  logic       i_mode_btn,
   input  logic       i_inc_btn,
   input  logic [5:0] i_sec_val,
   input  logic [5:0] i_min_val,
   output logic       o_sec_inc,
   output logic       o_min_inc,
   output logic       o_hour_inc,
   output logic       o_sec_clr,
   output logic [1:0] o_mode,
   output logic       o_blink
);
   import clock_pkg::*;

   localparam int                IDLE_W    = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 1);
   localparam logic [5:0]        SEC_TERM  = 6'(SEC_MAX);
   localparam logic [5:0]        MIN_TERM  = 6'(MIN_MAX);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [IDLE_W-1:0] r_idle;
   logic [IDLE_W-1:0] w_idle_nxt;
   logic              r_sec_inc, r_min_inc, r_hour_inc, r_sec_clr;
   logic              w_sec_inc_nxt, w_min_inc_nxt, w_hour_inc_nxt, w_sec_clr_nxt;
   logic              w_mode_edge;
   logic              w_inc_edge;
   logic              w_in_set;
   logic              w_timeout;

   edge_det u_mode_edge (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_lvl  (i_mode_btn),
      .o_rise (w_mode_edge)
   );

   edge_det u_inc_edge (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_lvl  (i_inc_btn),
      .o_rise (w_inc_edge)
   );

   assign w_in_set = is_set_mode(r_state);

   // Timeout fires on the tick that would bring the idle count to TIMEOUT_TICKS.
   // Any button edge in the same cycle clears the idle count, so it masks the timeout.
   assign w_timeout = w_in_set & i_tick_1hz & ~w_mode_edge & ~w_inc_edge &
                      (r_idle == IDLE_LAST);

   // State register (plus the registered outputs and idle counter).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= RUN;
         r_idle     <= '0;
         r_sec_inc  <= 1'b0;
         r_min_inc  <= 1'b0;
         r_hour_inc <= 1'b0;
         r_sec_clr  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_idle     <= w_idle_nxt;
         r_sec_inc  <= w_sec_inc_nxt;
         r_min_inc  <= w_min_inc_nxt;
         r_hour_inc <= w_hour_inc_nxt;
         r_sec_clr  <= w_sec_clr_nxt;
      end
   end

   // Next-state logic: mode_btn has priority over timeout.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN: begin
            if (w_mode_edge) w_state_nxt = SET_HOUR;
         end
         SET_HOUR: begin
            if (w_mode_edge)    w_state_nxt = SET_MIN;
            else if (w_timeout) w_state_nxt = RUN;
         end
         SET_MIN: begin
            if (w_mode_edge || w_timeout) w_state_nxt = RUN;
         end
         default: w_state_nxt = RUN;
      endcase
   end

   // Output logic: next values of the pulse registers and the idle counter.
   always_comb begin
      w_sec_inc_nxt  = 1'b0;
      w_min_inc_nxt  = 1'b0;
      w_hour_inc_nxt = 1'b0;
      w_sec_clr_nxt  = 1'b0;
      case (r_state)
         RUN: begin
            if (i_tick_1hz) begin
               w_sec_inc_nxt = 1'b1;
               if (i_sec_val == SEC_TERM) begin
                  w_min_inc_nxt = 1'b1;
                  if (i_min_val == MIN_TERM) w_hour_inc_nxt = 1'b1;
               end
            end
         end
         SET_HOUR: begin
            if (w_inc_edge && !w_mode_edge) w_hour_inc_nxt = 1'b1;
         end
         SET_MIN: begin
            if (w_inc_edge && !w_mode_edge) w_min_inc_nxt = 1'b1;
            // Leaving SET_MIN by either route zeroes the seconds.
            if (w_state_nxt == RUN) w_sec_clr_nxt = 1'b1;
         end
         default: ;
      endcase

      if (w_mode_edge || w_inc_edge || (w_state_nxt == RUN)) begin
         w_idle_nxt = '0;
      end else if (w_in_set && i_tick_1hz) begin
         w_idle_nxt = r_idle + 1'b1;
      end else begin
         w_idle_nxt = r_idle;
      end
   end

   assign o_sec_inc  = r_sec_inc;
   assign o_min_inc  = r_min_inc;
   assign o_hour_inc = r_hour_inc;
   assign o_sec_clr  = r_sec_clr;
   assign o_mode     = r_state;

`ifdef CLOCK_CTRL_BLINK_EN
   logic r_blink;
   logic w_blink_nxt;

   always_comb begin
      if (w_state_nxt == RUN)          w_blink_nxt = 1'b0;
      else if (w_in_set && i_tick_1hz) w_blink_nxt = ~r_blink;
      else                             w_blink_nxt = r_blink;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_blink <= 1'b0;
      else       r_blink <= w_blink_nxt;
   end

   assign o_blink = r_blink;
`else
   assign o_blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Purpose: self-checking bench for clock_ctrl (default parameters).
// Latency: each stimulus row expects its outputs one clock edge later.
// Backpressure: n/a.
module tb_clock_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       mode_btn = 1'b0;
   logic       inc_btn = 1'b0;
   logic [5:0] sec_val = '0;
   logic [5:0] min_val = '0;
   logic       sec_inc, min_inc, hour_inc, sec_clr, blink;
   logic [1:0] mode;

   always #5 clk = ~clk;

   clock_ctrl dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_tick_1hz (tick),
      .i_mode_btn (mode_btn),
      .i_inc_btn  (inc_btn),
      .i_sec_val  (sec_val),
      .i_min_val  (min_val),
      .o_sec_inc  (sec_inc),
      .o_min_inc  (min_inc),
      .o_hour_inc (hour_inc),
      .o_sec_clr  (sec_clr),
      .o_mode     (mode),
      .o_blink    (blink)
   );

   // {sec_inc, min_inc, hour_inc, sec_clr, mode, blink}
   typedef struct packed {
      logic       si;
      logic       mi;
      logic       hi;
      logic       sc;
      logic [1:0] md;
      logic       bl;
   } exp_t;

   typedef struct {
      int rst, t, m, i, s, mn;
      int si, mi, hi, sc, md;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   seen_min_inc = 0;
   int   seen_sec_clr = 0;
   bit   bl_model = 1'b0;
   int   prev_md = 0;

   task automatic add(input int rst, t, m, i, s, mn, si, mi, hi, sc, md);
      vec_t v;
      v.rst = rst; v.t = t; v.m = m; v.i = i; v.s = s; v.mn = mn;
      v.si = si; v.mi = mi; v.hi = hi; v.sc = sc; v.md = md;
      vecs.push_back(v);
   endtask

   // Drive one cycle of stimulus, queue the expected outputs, then check them after the edge.
   task automatic step(input int rst_i, t, m, i, s, mn, si, mi, hi, sc, md, input string nm);
      exp_t e;
      exp_t a;
      @(negedge clk);
      rst      = (rst_i != 0);
      tick     = (t != 0);
      mode_btn = (m != 0);
      inc_btn  = (i != 0);
      sec_val  = 6'(s);
      min_val  = 6'(mn);
`ifdef CLOCK_CTRL_BLINK_EN
      if (rst_i != 0 || md == 0)      bl_model = 1'b0;
      else if (t != 0 && prev_md != 0) bl_model = ~bl_model;
`else
      bl_model = 1'b0;
`endif
      prev_md = md;
      e.si = (si != 0); e.mi = (mi != 0); e.hi = (hi != 0); e.sc = (sc != 0);
      e.md = 2'(md);    e.bl = bl_model;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      a = {sec_inc, min_inc, hour_inc, sec_clr, mode, blink};
      if (min_inc) seen_min_inc++;
      if (sec_clr) seen_sec_clr++;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_errors++;
         $display("FAIL %s: scoreboard empty, got si/mi/hi/sc/mode/blink=%b", nm, a);
      end else begin
         e = sb_q.pop_front();
         if (a !== e) begin
            n_errors++;
            $display("FAIL %s @%0t: got si/mi/hi/sc/mode/blink=%b required %b", nm, $time, a, e);
         end
      end
   endtask

   task automatic idle_step(input int md, input string nm);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, md, nm);
   endtask

   task automatic tick_step(input int md, input string nm);
      step(0, 1, 0, 0, 10, 10, 0, 0, 0, 0, md, nm);
   endtask

   task automatic check_count(input int got, input int want, input string nm);
      n_checks++;
      if (got != want) begin
         n_errors++;
         $display("FAIL %s: got %0d required %0d", nm, got, want);
      end
   endtask

   initial begin
      //   rst t  m  i  sec min  si mi hi sc mode
      add(1, 0, 0, 0,  0,  0,   0, 0, 0, 0, 0);  // reset state
      add(1, 1, 0, 0, 59, 59,   0, 0, 0, 0, 0);  // tick ignored in reset
      add(0, 0, 0, 0,  0,  0,   0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 30,  0,   1, 0, 0, 0, 0);  // plain second
      add(0, 0, 0, 0, 30,  0,   0, 0, 0, 0, 0);
      add(0, 0, 0, 1, 30,  0,   0, 0, 0, 0, 0);  // inc ignored in RUN
      add(0, 0, 0, 0, 30,  0,   0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 59, 59,   1, 1, 1, 0, 0);  // full carry
      add(0, 0, 0, 0, 59, 59,   0, 0, 0, 0, 0);  // carry lasts one cycle
      add(0, 1, 0, 0, 59, 10,   1, 1, 0, 0, 0);  // minute carry only
      add(0, 1, 0, 0, 58, 59,   1, 0, 0, 0, 0);  // min at max but sec not
      add(0, 0, 1, 0,  0,  0,   0, 0, 0, 0, 1);  // -> SET_HOUR
      add(0, 1, 1, 0, 59, 59,   0, 0, 0, 0, 1);  // held btn, tick: no pulses
      add(0, 0, 0, 0,  0,  0,   0, 0, 0, 0, 1);
      add(0, 0, 0, 1,  0,  0,   0, 0, 1, 0, 1);  // hour_inc
      add(0, 0, 0, 1,  0,  0,   0, 0, 0, 0, 1);  // held inc: no repeat
      add(0, 0, 0, 0,  0,  0,   0, 0, 0, 0, 1);
      add(0, 0, 1, 0,  0,  0,   0, 0, 0, 0, 2);  // -> SET_MIN
      add(0, 0, 0, 0,  0,  0,   0, 0, 0, 0, 2);
      add(0, 1, 0, 1, 59, 59,   0, 1, 0, 0, 2);  // tick + inc: inc only
      add(0, 0, 0, 0,  0,  0,   0, 0, 0, 0, 2);
      add(0, 0, 1, 0,  0,  0,   0, 0, 0, 1, 0);  // -> RUN, sec_clr
      add(0, 0, 0, 0,  0,  0,   0, 0, 0, 0, 0);
      add(0, 0, 1, 0,  0,  0,   0, 0, 0, 0, 1);  // -> SET_HOUR
      add(0, 0, 0, 0,  0,  0,   0, 0, 0, 0, 1);
      add(0, 0, 1, 1,  0,  0,   0, 0, 0, 0, 2);  // mode+inc together: mode wins
      add(0, 0, 0, 0,  0,  0,   0, 0, 0, 0, 2);
      add(0, 0, 0, 1,  0,  0,   0, 1, 0, 0, 2);
      add(0, 0, 0, 0,  0,  0,   0, 0, 0, 0, 2);
      add(0, 0, 1, 0,  0,  0,   0, 0, 0, 1, 0);
      add(0, 0, 0, 0,  0,  0,   0, 0, 0, 0, 0);

      for (int k = 0; k < vecs.size(); k++) begin
         step(vecs[k].rst, vecs[k].t, vecs[k].m, vecs[k].i, vecs[k].s, vecs[k].mn,
              vecs[k].si, vecs[k].mi, vecs[k].hi, vecs[k].sc, vecs[k].md, $sformatf("vec%0d", k));
      end

      // Two mode edges, three inc edges, then back to RUN with one sec_clr.
      seen_min_inc = 0;
      seen_sec_clr = 0;
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "seq3_m1");
      idle_step(1, "seq3_rel1");
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, "seq3_m2");
      idle_step(2, "seq3_rel2");
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2, "seq3_inc");
         idle_step(2, "seq3_inc_rel");
      end
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "seq3_m3");
      idle_step(0, "seq3_rel3");
      check_count(seen_min_inc, 3, "seq3_min_inc_count");
      check_count(seen_sec_clr, 1, "seq3_sec_clr_count");

      // SET_HOUR timeout: 30 idle ticks back to RUN, no sec_clr.
      seen_sec_clr = 0;
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "to_hour_enter");
      idle_step(1, "to_hour_rel");
      for (int k = 1; k < 30; k++) begin
         tick_step(1, $sformatf("to_hour_tick%0d", k));
         idle_step(1, "to_hour_gap");
      end
      tick_step(0, "to_hour_tick30");
      idle_step(0, "to_hour_after");
      check_count(seen_sec_clr, 0, "to_hour_no_sec_clr");

      // SET_MIN timeout: 30 idle ticks back to RUN with sec_clr.
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "to_min_m1");
      idle_step(1, "to_min_rel1");
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, "to_min_m2");
      idle_step(2, "to_min_rel2");
      for (int k = 1; k < 30; k++) tick_step(2, $sformatf("to_min_tick%0d", k));
      step(0, 1, 0, 0, 10, 10, 0, 0, 0, 1, 0, "to_min_tick30");
      idle_step(0, "to_min_after");

      // Mode edge coincident with the timeout tick: mode edge wins.
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "race_enter");
      idle_step(1, "race_rel");
      for (int k = 1; k < 30; k++) tick_step(1, $sformatf("race_tick%0d", k));
      step(0, 1, 1, 0, 10, 10, 0, 0, 0, 0, 2, "race_tick30_mode");
      idle_step(2, "race_rel2");
      for (int k = 1; k < 30; k++) tick_step(2, $sformatf("race_min_tick%0d", k));
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "race_exit");
      idle_step(0, "race_exit_rel");

      // Reset in SET_MIN abandons it without sec_clr.
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "rst_set_m1");
      idle_step(1, "rst_set_rel1");
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, "rst_set_m2");
      idle_step(2, "rst_set_rel2");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_set_rst");
      idle_step(0, "rst_set_after");

      // Mode button held through reset release is ignored until re-pressed.
      step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "hold_rst");
      for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "hold_after_rst");
      idle_step(0, "hold_release");
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "hold_repress");
      idle_step(1, "hold_rel2");
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, "hold_m2");
      idle_step(2, "hold_rel3");
      step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "hold_m3");
      idle_step(0, "hold_end");

      check_count(sb_q.size(), 0, "scoreboard_drained");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
